sd_arbiter: RTL

//  Shares the single SD block channel (lba/rd/wr/ack, byte strobes, data) among NREQ disk

---
 rtl/sd_arb_pkg.sv | 21 ++
 rtl/sd_arbiter_rr_pick.sv | 29 ++
 rtl/sd_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD block-channel arbiter.
package sd_arb_pkg;

    typedef enum logic [2:0] {
        DRAIN   = 3'd0,
        IDLE    = 3'd1,
        ISSUE   = 3'd2,
        XFER    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int MAX_NREQ = 4;
    localparam int LBA_W    = 32;
    localparam int IDX_W    = $clog2(MAX_NREQ);

    // Round-robin successor of a requester index, wrapping at nreq.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx, input int nreq);
        return (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending requester at or after ptr, wrapping at NREQ.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && (i == (int'(ptr) + k) % NREQ) && pending[i]) begin
                    any       = 1'b1;
                    idx       = IDX_W'(i);
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sd_arbiter.sv
// Round-robin arbiter sharing one SD block channel among NREQ requesters.
// Optional issue-to-ack watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 2**20
) (
    input  logic                  clk_ram,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_rd,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [NREQ-1:0]       req_conf,
    input  logic [NREQ*LBA_W-1:0] req_lba,
    input  logic [NREQ*8-1:0]     req_din,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       gnt_ack,
    output logic [NREQ-1:0]       gnt_dout_strobe,
    output logic [NREQ-1:0]       gnt_din_strobe,
    output logic [NREQ-1:0]       gnt_err,
    output logic [LBA_W-1:0]      sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    output logic                  sd_conf,
    output logic [7:0]            sd_din,
    input  logic                  sd_ack,
    input  logic                  sd_dout_strobe,
    input  logic                  sd_din_strobe,
    output state_t                state_dbg
);

    // Handshake: req_rd/req_wr are levels. A requester raises one and holds it until its
    // gnt_ack falls; dropping both before the ack rises cancels the request, after that it is ignored.

    logic ack_m, ack_s;

    // sd_ack comes from another clock domain; the synchroniser is deliberately not reset so
    // DRAIN sees the true ack level right after reset.
    always_ff @(posedge clk_ram) begin
        ack_m <= sd_ack;
        ack_s <= ack_m;
    end

    state_t            state_q, state_nx;
    logic [NREQ-1:0]   gnt_q, gnt_nx;
    logic [IDX_W-1:0]  idx_q, idx_nx;
    logic [IDX_W-1:0]  ptr_q, ptr_nx;
    logic [LBA_W-1:0]  lba_q, lba_nx;
    logic              rd_q, rd_nx;
    logic              wr_q, wr_nx;
    logic              conf_q, conf_nx;

    logic [NREQ-1:0]   pending;
    logic [NREQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [LBA_W-1:0]  pick_lba;
    logic              gnt_pending;

`ifdef SD_ARB_TIMEOUT_EN
    logic [31:0]       cnt_q, cnt_nx;
    logic [NREQ-1:0]   err_q, err_nx;
`endif

    assign pending     = req_rd | req_wr;
    assign gnt_pending = |(pending & gnt_q);

    rr_pick #(.NREQ(NREQ)) u_pick (
        .pending (pending),
        .ptr     (ptr_q),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        pick_lba = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) pick_lba = req_lba[i*LBA_W +: LBA_W];
        end
    end

    always_comb begin
        state_nx = state_q;
        gnt_nx   = gnt_q;
        idx_nx   = idx_q;
        ptr_nx   = ptr_q;
        lba_nx   = lba_q;
        rd_nx    = rd_q;
        wr_nx    = wr_q;
        conf_nx  = conf_q;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_nx   = cnt_q;
        err_nx   = '0;
`endif
        case (state_q)
            DRAIN: begin
                if (!ack_s) state_nx = IDLE;
            end
            IDLE: begin
                if (pick_any) begin
                    state_nx = ISSUE;
                    gnt_nx   = pick_onehot;
                    idx_nx   = pick_idx;
                    lba_nx   = pick_lba;
                    conf_nx  = |(req_conf & pick_onehot);
                    rd_nx    = |(req_rd & pick_onehot);
                    wr_nx    = |(req_wr & pick_onehot) & ~|(req_rd & pick_onehot);
`ifdef SD_ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            ISSUE: begin
                if (ack_s) begin
                    state_nx = XFER;
                end else if (!gnt_pending) begin
                    // Cancelled before the card answered: the requester keeps its turn.
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    state_nx = DRAIN;
                    err_nx   = gnt_q;
                    gnt_nx   = '0;
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    ptr_nx   = next_ptr(idx_q, NREQ);
                end else begin
                    cnt_nx   = cnt_q + 32'd1;
                end
`endif
            end
            XFER: begin
                if (!ack_s) begin
                    state_nx = RELEASE;
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                ptr_nx   = next_ptr(idx_q, NREQ);
            end
            default: begin
                state_nx = DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state_q <= DRAIN;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            conf_q  <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_nx;
            gnt_q   <= gnt_nx;
            idx_q   <= idx_nx;
            ptr_q   <= ptr_nx;
            lba_q   <= lba_nx;
            rd_q    <= rd_nx;
            wr_q    <= wr_nx;
            conf_q  <= conf_nx;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q   <= cnt_nx;
            err_q   <= err_nx;
`endif
        end
    end

    // Byte data to the card comes straight from the granted requester; zero with no grant.
    always_comb begin
        sd_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) sd_din = req_din[i*8 +: 8];
        end
    end

    assign gnt             = gnt_q;
    assign gnt_ack         = {NREQ{sd_ack}} & gnt_q;
    assign gnt_dout_strobe = {NREQ{sd_dout_strobe}} & gnt_q;
    assign gnt_din_strobe  = {NREQ{sd_din_strobe}} & gnt_q;
    assign sd_lba          = lba_q;
    assign sd_rd           = rd_q;
    assign sd_wr           = wr_q;
    assign sd_conf         = conf_q;
    assign state_dbg       = state_q;

`ifdef SD_ARB_TIMEOUT_EN
    assign gnt_err = err_q;
`else
    assign gnt_err = '0;
`endif

endmodule
